commutation_scheduler: RTL and testbench
========================================

# commutation_scheduler

Six-step commutation scheduler for the 8-bit switch-pattern output stage. It steps through the six fixed drive patterns with a programmable dwell per step and a programmable all-off dead time between steps. It supports forward and reverse rotation, stop/start, and a latched fault shutdown. It sits between the control registers (`enable`, `dir`, `period`, `deadtime`) and the output drivers, and is the only block that drives `out`.

## Interface
Parameters:
- `PERIOD_W`, default 16: width of the step dwell period, in clocks.
- `DEAD_W`, default 4: width of the dead-time count, in clocks.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high.
- `enable`, input, 1: run request, level-sensitive.
- `dir`, input, 1: 0 = forward (step+1), 1 = reverse (step−1). Sampled at each step advance.
- `period`, input, `PERIOD_W`: dwell cycles per step. A value of 0 is treated as 1. Latched at the start of each drive step.
- `deadtime`, input, `DEAD_W`: all-off cycles between steps. A value of 0 skips dead time. Latched at the end of each drive step.
- `fault`, input, 1: synchronous fault request, active-high.
- `out`, output, 8: switch pattern, registered.
- `step`, output, 3: current step index 0..5, registered.
- `step_pulse`, output, 1: one-cycle strobe when a new step's pattern first appears on `out`.
- `busy`, output, 1: high in DRIVE or DEAD.
- `fault_latched`, output, 1: high in FAULT.

## Operation
Pattern table, indexed by step:
- Step 0: 8'b10010000
- Step 1: 8'b00011000
- Step 2: 8'b01001000
- Step 3: 8'b01100000
- Step 4: 8'b00100100
- Step 5: 8'b10000100
- Any other index never occurs. If it does, `out` = 0.

States are IDLE, DRIVE, DEAD and FAULT. Priority: `fault` > `enable`=0 > timer events.

- **IDLE**
  - `out` = 0, `busy` = 0.
  - If `fault`: go to FAULT.
  - Else if `enable`: go to DRIVE with the current `step` and load the dwell timer with the effective period. `step_pulse` fires on entry.
- **DRIVE**
  - `out` = pattern(step).
  - The dwell timer counts down, so DRIVE lasts exactly the effective period in cycles.
  - On the last dwell cycle:
    - If latched deadtime = 0: advance `step` and re-enter DRIVE immediately with the new pattern. `step_pulse` fires.
    - Otherwise: go to DEAD for `deadtime` cycles.
- **DEAD**
  - `out` = 0, `step` unchanged.
  - After `deadtime` cycles: advance `step`, go to DRIVE, and fire `step_pulse`.
- **FAULT**
  - `out` = 0, `busy` = 0, `fault_latched` = 1.
  - Exit to IDLE only when `fault` = 0 and `enable` = 0 in the same cycle. `step` is held.

Step advance:
- Forward: 5 → 0 wrap.
- Reverse: 0 → 5 wrap.

Mid-run events:
- `enable` falling in DRIVE or DEAD: the next state is IDLE and `out` = 0 on the next edge. `step` is held, with no advance even if the drop occurs in the final dead cycle.
- A restart resumes at the held `step`.
- `fault` in any state: FAULT on the next edge. This overrides a simultaneous step advance.

Timer rules:
- Changes to `period`/`deadtime` mid-step take effect only at the next latch point.
- Timers saturate and never wrap.

Reset values: state = IDLE, `out` = 0, `step` = 0, `step_pulse` = 0, `busy` = 0, `fault_latched` = 0, all timers = 0.

## Timing
- All outputs are registered. Inputs are sampled at the rising edge of `clk`.
- Start latency: `enable` sampled high at edge N gives `out` = pattern(step) and `step_pulse` = 1 after edge N.
- A steady-state cycle is period_eff DRIVE cycles plus `deadtime` DEAD cycles per step. A full revolution is 6 × (period_eff + deadtime) cycles.
- `step_pulse` is exactly 1 cycle wide and coincides with the first cycle of each new pattern.
- Stop/fault latency is one edge. `out` is never nonzero in the cycle after a sampled `fault`.
- The pattern-to-pattern transition with deadtime > 0 always passes through at least one `out` = 0 cycle.
- Asynchronous reset takes effect immediately and mid-step, with no glitch beyond the flops clearing.

## Test plan
- **Forward run:** reset, then period = 3, deadtime = 2, dir = 0, enable = 1 for 40 cycles.
  - `out` sequence: 0x90 ×3, 0 ×2, 0x18 ×3, 0 ×2, 0x48 …, wrapping 0x84 → 0x90.
  - `step_pulse` every 5 cycles.
- **Reverse with no dead time:** period = 2, deadtime = 0, dir = 1, starting from step 0.
  - Steps 0, 5, 4, 3 … with back-to-back patterns 0x90, 0x84, 0x24, and no zero cycles.
- **Period 0:** period = 0.
  - Each step lasts 1 cycle. Behaviour is identical to period = 1.
- **Stop/restart:** drop `enable` during DEAD after step 2.
  - `out` = 0 and `step` = 2 on the next edge, `busy` = 0.
  - On re-enable, `out` = 0x48 with `step_pulse`.
- **Fault:** assert `fault` for 1 cycle while in DRIVE on step 3.
  - `out` = 0 and `fault_latched` = 1 on the next edge.
  - The block stays in FAULT while `enable` = 1.
  - After `enable` = 0, it returns to IDLE.
  - Re-enabling resumes at step 3 (0x60).
- **Async reset:** assert `reset` mid-step 4 between clock edges.
  - `out` = 0 and `step` = 0 immediately.
  - After reset releases, it restarts at 0x90.

Source files
------------

// File: rtl/commutation_scheduler_if.sv
// commutation_scheduler_if
//   Bundles the control-register inputs and the drive-stage outputs of the
//   six-step commutation scheduler.
//   master : control side (drives enable/dir/period/deadtime/fault, observes outputs)
//   slave  : the scheduler itself
// Signals:
//   enable        run request, level-sensitive
//   dir           0 = forward, 1 = reverse
//   period        dwell cycles per step (0 behaves as 1)
//   deadtime      all-off cycles between steps (0 = none)
//   fault         synchronous fault request
//   out           8-bit switch pattern
//   step          current step index 0..5
//   step_pulse    one-cycle strobe on the first cycle of a new pattern
//   busy          high while driving or in dead time
//   fault_latched high while in the fault state
interface commutation_scheduler_if #(
  parameter int PERIOD_W = 16,
  parameter int DEAD_W   = 4
);
  logic                enable;
  logic                dir;
  logic [PERIOD_W-1:0] period;
  logic [DEAD_W-1:0]   deadtime;
  logic                fault;
  logic [7:0]          out;
  logic [2:0]          step;
  logic                step_pulse;
  logic                busy;
  logic                fault_latched;

  modport master (
    output enable, dir, period, deadtime, fault,
    input  out, step, step_pulse, busy, fault_latched
  );

  modport slave (
    input  enable, dir, period, deadtime, fault,
    output out, step, step_pulse, busy, fault_latched
  );
endinterface

// File: rtl/commutation_scheduler.sv
// commutation_scheduler
//   Six-step commutation scheduler. Walks the six fixed switch patterns with a
//   programmable dwell per step and an optional all-off dead time between
//   steps, in either rotation direction, with stop/start and a latched fault
//   shutdown. All outputs are registered.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   bus    commutation_scheduler_if.slave (control inputs, drive outputs)
module commutation_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int DEAD_W   = 4
) (
  input logic                    clk,
  input logic                    reset,
  commutation_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DEAD,
    ST_FAULT
  } state_t;

  state_t              state_q, state_next;
  logic [2:0]          step_q, step_next;
  logic [PERIOD_W-1:0] dwell_q, dwell_next;
  logic [DEAD_W-1:0]   dead_q, dead_next;

  logic [7:0]          out_q, out_next;
  logic                pulse_q, pulse_next;
  logic                busy_q, busy_next;
  logic                fault_q, fault_next;

  logic [PERIOD_W-1:0] period_eff;

  // Switch pattern for each step; an out-of-range index drives everything off.
  function automatic logic [7:0] pattern_of(input logic [2:0] s);
    case (s)
      3'd0:    pattern_of = 8'b1001_0000;
      3'd1:    pattern_of = 8'b0001_1000;
      3'd2:    pattern_of = 8'b0100_1000;
      3'd3:    pattern_of = 8'b0110_0000;
      3'd4:    pattern_of = 8'b0010_0100;
      3'd5:    pattern_of = 8'b1000_0100;
      default: pattern_of = 8'b0000_0000;
    endcase
  endfunction

  // Next step index with wrap in both directions.
  function automatic logic [2:0] advance_step(input logic [2:0] s, input logic reverse);
    if (reverse)
      advance_step = (s == 3'd0 || s > 3'd5) ? 3'd5 : s - 3'd1;
    else
      advance_step = (s >= 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  // A programmed period of zero still gives one drive cycle per step.
  assign period_eff = (bus.period == '0) ? PERIOD_W'(1) : bus.period;

  // State and output registers; outputs are flopped from their next values so
  // every output is a clean register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
      dwell_q <= '0;
      dead_q  <= '0;
      out_q   <= 8'h00;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_next;
      step_q  <= step_next;
      dwell_q <= dwell_next;
      dead_q  <= dead_next;
      out_q   <= out_next;
      pulse_q <= pulse_next;
      busy_q  <= busy_next;
      fault_q <= fault_next;
    end
  end

  // Next-state logic. Fault beats a stop request, which beats any timer event,
  // so a stop or fault never lets the step advance. Timers count down and only
  // decrement while above one, so they cannot wrap.
  always_comb begin
    state_next = state_q;
    step_next  = step_q;
    dwell_next = dwell_q;
    dead_next  = dead_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.fault) begin
          state_next = ST_FAULT;
        end else if (bus.enable) begin
          state_next = ST_DRIVE;
          dwell_next = period_eff;
        end
      end
      ST_DRIVE: begin
        if (bus.fault) begin
          state_next = ST_FAULT;
        end else if (!bus.enable) begin
          state_next = ST_IDLE;
        end else if (dwell_q <= PERIOD_W'(1)) begin
          if (bus.deadtime == '0) begin
            step_next  = advance_step(step_q, bus.dir);
            dwell_next = period_eff;
          end else begin
            state_next = ST_DEAD;
            dead_next  = bus.deadtime;
          end
        end else begin
          dwell_next = dwell_q - PERIOD_W'(1);
        end
      end
      ST_DEAD: begin
        if (bus.fault) begin
          state_next = ST_FAULT;
        end else if (!bus.enable) begin
          state_next = ST_IDLE;
        end else if (dead_q <= DEAD_W'(1)) begin
          state_next = ST_DRIVE;
          step_next  = advance_step(step_q, bus.dir);
          dwell_next = period_eff;
        end else begin
          dead_next = dead_q - DEAD_W'(1);
        end
      end
      ST_FAULT: begin
        if (!bus.fault && !bus.enable)
          state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic from the upcoming state. A new pattern appears whenever the
  // next state is DRIVE and we either were not driving or the step changed;
  // every advance changes the index, so this catches back-to-back steps too.
  always_comb begin
    out_next   = (state_next == ST_DRIVE) ? pattern_of(step_next) : 8'h00;
    busy_next  = (state_next == ST_DRIVE) || (state_next == ST_DEAD);
    fault_next = (state_next == ST_FAULT);
    pulse_next = (state_next == ST_DRIVE) &&
                 ((state_q != ST_DRIVE) || (step_next != step_q));
  end

  assign bus.out           = out_q;
  assign bus.step          = step_q;
  assign bus.step_pulse    = pulse_q;
  assign bus.busy          = busy_q;
  assign bus.fault_latched = fault_q;

endmodule

// File: tb/tb_commutation_scheduler.sv
// tb_commutation_scheduler
//   Self-checking bench for commutation_scheduler: a table of directed cycles
//   (forward run, stop/restart in dead time, fault), hand-written sequences
//   (reverse with no dead time, period zero with wrap, async reset mid-step)
//   and a randomized run compared against a step-timeline reference model.
module tb_commutation_scheduler;

  logic clk;
  logic reset;

  commutation_scheduler_if #(.PERIOD_W(16), .DEAD_W(4)) bus_if ();

  commutation_scheduler #(.PERIOD_W(16), .DEAD_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passes;

  typedef struct {
    logic        enable;
    logic        dir;
    logic        fault;
    logic [15:0] period;
    logic [3:0]  deadtime;
    logic [7:0]  e_out;
    logic [2:0]  e_step;
    logic        e_pulse;
    logic        e_busy;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] pat_tbl [6] = '{8'h90, 8'h18, 8'h48, 8'h60, 8'h24, 8'h84};

  // Reference model: position within the current step counted upward from the
  // first drive cycle; a step is plen drive cycles followed by dlen off cycles.
  bit m_run, m_flt, m_pulse;
  int m_step, m_pos, m_plen, m_dlen;

  // Compare one value and keep the tallies.
  task automatic check_val(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Compare all DUT outputs against expected values.
  task automatic check_output(input string nm, input logic [7:0] e_out, input logic [2:0] e_step,
                              input logic e_pulse, input logic e_busy, input logic e_fault);
    check_val({nm, ".out"},   bus_if.out,                 e_out);
    check_val({nm, ".step"},  8'(bus_if.step),            8'(e_step));
    check_val({nm, ".pulse"}, 8'(bus_if.step_pulse),      8'(e_pulse));
    check_val({nm, ".busy"},  8'(bus_if.busy),            8'(e_busy));
    check_val({nm, ".fault"}, 8'(bus_if.fault_latched),   8'(e_fault));
  endtask

  // Drive the control inputs.
  task automatic apply_stimulus(input logic en, input logic dr, input logic ft,
                                input logic [15:0] per, input logic [3:0] dt);
    bus_if.enable   = en;
    bus_if.dir      = dr;
    bus_if.fault    = ft;
    bus_if.period   = per;
    bus_if.deadtime = dt;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking reset pulse, released away from the clock edge.
  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic en, input logic dr, input logic ft, input logic [15:0] per,
                         input logic [3:0] dt, input logic [7:0] eo, input logic [2:0] es,
                         input logic ep, input logic eb, input logic ef);
    vec_t v;
    v.enable = en; v.dir = dr; v.fault = ft; v.period = per; v.deadtime = dt;
    v.e_out = eo; v.e_step = es; v.e_pulse = ep; v.e_busy = eb; v.e_fault = ef;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    m_run = 0; m_flt = 0; m_pulse = 0;
    m_step = 0; m_pos = 0; m_plen = 0; m_dlen = 0;
  endtask

  // Predict the outcome of one clock edge given the sampled inputs.
  task automatic model_edge(input bit en, input bit dr, input bit ft, input int per, input int dt);
    int eff;
    eff = (per == 0) ? 1 : per;
    m_pulse = 0;
    if (m_flt) begin
      if (!ft && !en) m_flt = 0;
    end else if (ft) begin
      m_flt = 1;
      m_run = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1; m_pos = 0; m_plen = eff; m_pulse = 1;
      end
    end else if (!en) begin
      m_run = 0;
    end else begin
      m_pos++;
      if (m_pos == m_plen) m_dlen = dt;
      if (m_pos >= m_plen && m_pos >= m_plen + m_dlen) begin
        m_step  = dr ? (m_step + 5) % 6 : (m_step + 1) % 6;
        m_pos   = 0;
        m_plen  = eff;
        m_pulse = 1;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    return (m_run && m_pos < m_plen) ? pat_tbl[m_step] : 8'h00;
  endfunction

  // Main test sequence.
  initial begin
    logic [7:0] rev_out [7] = '{8'h90, 8'h90, 8'h84, 8'h84, 8'h24, 8'h24, 8'h60};
    logic [2:0] rev_step [7] = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd4, 3'd4, 3'd3};
    logic       rev_pulse [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] p0_out [7] = '{8'h90, 8'h18, 8'h48, 8'h60, 8'h24, 8'h84, 8'h90};
    logic       r_en, r_dir, r_flt;
    logic [15:0] r_per;
    logic [3:0]  r_dt;

    checks = 0;
    passes = 0;

    // Forward run, period 3 / dead 2, stop during dead time after step 2,
    // restart, then a one-cycle fault on step 3.
    add_vec(1,0,0,3,2, 8'h90,0,1,1,0);
    add_vec(1,0,0,3,2, 8'h90,0,0,1,0);
    add_vec(1,0,0,3,2, 8'h90,0,0,1,0);
    add_vec(1,0,0,3,2, 8'h00,0,0,1,0);
    add_vec(1,0,0,3,2, 8'h00,0,0,1,0);
    add_vec(1,0,0,3,2, 8'h18,1,1,1,0);
    add_vec(1,0,0,3,2, 8'h18,1,0,1,0);
    add_vec(1,0,0,3,2, 8'h18,1,0,1,0);
    add_vec(1,0,0,3,2, 8'h00,1,0,1,0);
    add_vec(1,0,0,3,2, 8'h00,1,0,1,0);
    add_vec(1,0,0,3,2, 8'h48,2,1,1,0);
    add_vec(1,0,0,3,2, 8'h48,2,0,1,0);
    add_vec(1,0,0,3,2, 8'h48,2,0,1,0);
    add_vec(1,0,0,3,2, 8'h00,2,0,1,0);
    add_vec(0,0,0,3,2, 8'h00,2,0,0,0);
    add_vec(1,0,0,3,2, 8'h48,2,1,1,0);
    add_vec(1,0,0,3,2, 8'h48,2,0,1,0);
    add_vec(1,0,0,3,2, 8'h48,2,0,1,0);
    add_vec(1,0,0,3,2, 8'h00,2,0,1,0);
    add_vec(1,0,0,3,2, 8'h00,2,0,1,0);
    add_vec(1,0,0,3,2, 8'h60,3,1,1,0);
    add_vec(1,0,1,3,2, 8'h00,3,0,0,1);
    add_vec(1,0,0,3,2, 8'h00,3,0,0,1);
    add_vec(0,0,0,3,2, 8'h00,3,0,0,0);
    add_vec(1,0,0,3,2, 8'h60,3,1,1,0);

    apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    reset = 1'b1;
    tick();
    tick();
    check_output("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    $display("[TB] directed table");
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].enable, vecs[i].dir, vecs[i].fault, vecs[i].period, vecs[i].deadtime);
      tick();
      check_output($sformatf("tbl%0d", i), vecs[i].e_out, vecs[i].e_step,
                   vecs[i].e_pulse, vecs[i].e_busy, vecs[i].e_fault);
    end

    $display("[TB] reverse, no dead time");
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'd2, 4'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_output($sformatf("rev%0d", i), rev_out[i], rev_step[i], rev_pulse[i], 1'b1, 1'b0);
    end

    $display("[TB] period zero, forward wrap");
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_output($sformatf("p0_%0d", i), p0_out[i], 3'(i % 6), 1'b1, 1'b1, 1'b0);
    end

    $display("[TB] async reset mid-step");
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'd3, 4'd0);
    repeat (14) tick();
    check_output("pre_areset", 8'h24, 3'd4, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_output("areset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    bus_if.enable = 1'b0;
    #2;
    reset = 1'b0;
    bus_if.enable = 1'b1;
    tick();
    check_output("post_areset", 8'h90, 3'd0, 1'b1, 1'b1, 1'b0);

    $display("[TB] randomized run");
    do_reset();
    model_reset();
    r_en = 1'b1; r_dir = 1'b0; r_flt = 1'b0; r_per = 16'd2; r_dt = 4'd1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 5)  r_en  = ~r_en;
      if ($urandom_range(0, 99) < 10) r_dir = ~r_dir;
      r_flt = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 10) r_per = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 99) < 10) r_dt  = 4'($urandom_range(0, 3));
      apply_stimulus(r_en, r_dir, r_flt, r_per, r_dt);
      model_edge(r_en, r_dir, r_flt, int'(r_per), int'(r_dt));
      tick();
      check_output($sformatf("rnd%0d", i), model_out(), 3'(m_step), m_pulse, m_run, m_flt);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
